// File: rtl/text_pixel_renderer_if.sv
// Signal bundle between the VGA timing generator, text/font memories and the text pixel renderer.
// The renderer takes the slave view; the timing/memory side takes the master view.
interface text_pixel_renderer_if;
  logic        pix_en;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        bright;
  logic        hsync_in;
  logic        vsync_in;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_en;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_n_out;

  modport slave (
    input  pix_en, x, y, bright, hsync_in, vsync_in,
    input  cursor_col, cursor_row, cursor_en,
    input  text_data, font_data,
    output text_addr, font_addr,
    output r, g, b, hsync_out, vsync_out, blank_n_out
  );

  modport master (
    output pix_en, x, y, bright, hsync_in, vsync_in,
    output cursor_col, cursor_row, cursor_en,
    output text_data, font_data,
    input  text_addr, font_addr,
    input  r, g, b, hsync_out, vsync_out, blank_n_out
  );
endinterface

// File: rtl/text_pixel_renderer.sv
// 80x30 text console pixel pipeline: text RAM fetch, font ROM fetch, colour/cursor overlay.
// Three pix_en-qualified stages; syncs and blank ride alongside so they stay aligned with RGB.
module text_pixel_renderer #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic                  clk,
  input logic                  rst,
  text_pixel_renderer_if.slave bus
);
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // stage 1: text fetch
  logic [11:0] text_addr_q, text_addr_d;
  logic [2:0]  bit1_q, bit1_d;
  logic [3:0]  grow1_q, grow1_d;
  logic        bright1_q, bright1_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic        cur1_q, cur1_d;

  // stage 2: font fetch
  logic [10:0] font_addr_q, font_addr_d;
  logic [2:0]  bit2_q, bit2_d;
  logic        inv2_q, inv2_d;
  logic        bright2_q, bright2_d;
  logic        hs2_q, hs2_d;
  logic        vs2_q, vs2_d;
  logic        cur2_q, cur2_d;

  // stage 3: outputs
  logic [23:0] rgb_q, rgb_d;
  logic        hs_out_q, hs_out_d;
  logic        vs_out_q, vs_out_d;
  logic        blank_n_q, blank_n_d;

  // cursor blink
  logic             vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;

  logic [11:0] cell_addr;
  logic        cur_hit;
  logic        pix_on;
  logic        vs_fall;

  always_comb begin
    cell_addr = 12'(12'(bus.y[8:4]) * 12'(COLS) + 12'(bus.x[9:3]));
    // rows past the console never draw a cursor, even if cursor_row is out of range
    cur_hit   = bus.cursor_en
              & (bus.x[9:3] == bus.cursor_col)
              & (bus.y[8:4] == bus.cursor_row)
              & (32'(bus.cursor_row) < ROWS);
    pix_on    = bus.font_data[3'd7 - bit2_q] ^ inv2_q ^ (cur2_q & blink_on_q);
    vs_fall   = vs_prev_q & ~bus.vsync_in;

    text_addr_d = text_addr_q;
    bit1_d      = bit1_q;
    grow1_d     = grow1_q;
    bright1_d   = bright1_q;
    hs1_d       = hs1_q;
    vs1_d       = vs1_q;
    cur1_d      = cur1_q;
    font_addr_d = font_addr_q;
    bit2_d      = bit2_q;
    inv2_d      = inv2_q;
    bright2_d   = bright2_q;
    hs2_d       = hs2_q;
    vs2_d       = vs2_q;
    cur2_d      = cur2_q;
    rgb_d       = rgb_q;
    hs_out_d    = hs_out_q;
    vs_out_d    = vs_out_q;
    blank_n_d   = blank_n_q;
    vs_prev_d   = vs_prev_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;

    if (bus.pix_en) begin
      text_addr_d = bus.bright ? cell_addr : '0;
      bit1_d      = bus.x[2:0];
      grow1_d     = bus.y[3:0];
      bright1_d   = bus.bright;
      hs1_d       = bus.hsync_in;
      vs1_d       = bus.vsync_in;
      cur1_d      = cur_hit;

      font_addr_d = {bus.text_data[6:0], grow1_q};
      inv2_d      = bus.text_data[7];
      bit2_d      = bit1_q;
      bright2_d   = bright1_q;
      hs2_d       = hs1_q;
      vs2_d       = vs1_q;
      cur2_d      = cur1_q;

      rgb_d       = !bright2_q ? '0 : (pix_on ? FG_COLOR : BG_COLOR);
      hs_out_d    = hs2_q;
      vs_out_d    = vs2_q;
      blank_n_d   = bright2_q;

      vs_prev_d = bus.vsync_in;
      if (vs_fall) begin
        if (blink_cnt_q == CNT_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // sync pipeline flags reset to the inactive (high) level so no spurious pulse follows reset
  always_ff @(posedge clk) begin
    if (rst) begin
      text_addr_q <= '0;
      bit1_q      <= '0;
      grow1_q     <= '0;
      bright1_q   <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      cur1_q      <= 1'b0;
      font_addr_q <= '0;
      bit2_q      <= '0;
      inv2_q      <= 1'b0;
      bright2_q   <= 1'b0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      cur2_q      <= 1'b0;
      rgb_q       <= '0;
      hs_out_q    <= 1'b1;
      vs_out_q    <= 1'b1;
      blank_n_q   <= 1'b0;
      vs_prev_q   <= 1'b1;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      text_addr_q <= text_addr_d;
      bit1_q      <= bit1_d;
      grow1_q     <= grow1_d;
      bright1_q   <= bright1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      cur1_q      <= cur1_d;
      font_addr_q <= font_addr_d;
      bit2_q      <= bit2_d;
      inv2_q      <= inv2_d;
      bright2_q   <= bright2_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      cur2_q      <= cur2_d;
      rgb_q       <= rgb_d;
      hs_out_q    <= hs_out_d;
      vs_out_q    <= vs_out_d;
      blank_n_q   <= blank_n_d;
      vs_prev_q   <= vs_prev_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign bus.text_addr   = text_addr_q;
  assign bus.font_addr   = font_addr_q;
  assign bus.r           = rgb_q[23:16];
  assign bus.g           = rgb_q[15:8];
  assign bus.b           = rgb_q[7:0];
  assign bus.hsync_out   = hs_out_q;
  assign bus.vsync_out   = vs_out_q;
  assign bus.blank_n_out = blank_n_q;
endmodule

// File: tb/tb_text_pixel_renderer.sv
// Bench for text_pixel_renderer: directed console scenarios plus randomized pixel stream,
// checked against a cell/glyph reference model with a history of sampled inputs.
module tb_text_pixel_renderer;
  localparam int COLS = 80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_pixel_renderer_if vif ();

  text_pixel_renderer #(
    .COLS(80), .ROWS(30), .FG_COLOR(24'hFFFFFF), .BG_COLOR(24'h000000), .BLINK_FRAMES(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif.slave)
  );

  logic [7:0] tram [0:4095];
  logic [7:0] from [0:2047];
  assign vif.text_data = tram[vif.text_addr];
  assign vif.font_data = from[vif.font_addr];

  typedef struct {
    int x; int y;
    bit br; bit hs; bit vs; bit cen;
    int ccol; int crow;
  } samp_t;

  samp_t hist[$];
  int    falls;
  bit    prev_vs;
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cell_of(samp_t s);
    return s.br ? (s.y / 16) * COLS + s.x / 8 : 0;
  endfunction

  function automatic logic [23:0] exp_rgb(samp_t s, bit blink);
    int col, row;
    logic [7:0] ch, gl;
    bit on;
    if (!s.br) return 24'h000000;
    col = s.x / 8;
    row = s.y / 16;
    ch  = tram[row * COLS + col];
    gl  = from[(ch % 128) * 16 + s.y % 16];
    on  = gl[7 - s.x % 8] ^ ch[7] ^ (s.cen && col == s.ccol && row == s.crow && blink);
    return on ? 24'hFFFFFF : 24'h000000;
  endfunction

  task automatic tick(input bit pe);
    samp_t s;
    logic [23:0] pre_rgb;
    logic [11:0] pre_ta;
    logic [10:0] pre_fa;
    logic [2:0]  pre_sy;
    bit blink;
    int n;
    s.x = int'(vif.x); s.y = int'(vif.y);
    s.br = vif.bright; s.hs = vif.hsync_in; s.vs = vif.vsync_in;
    s.cen = vif.cursor_en; s.ccol = int'(vif.cursor_col); s.crow = int'(vif.cursor_row);
    pre_rgb = {vif.r, vif.g, vif.b};
    pre_ta  = vif.text_addr;
    pre_fa  = vif.font_addr;
    pre_sy  = {vif.hsync_out, vif.vsync_out, vif.blank_n_out};
    vif.pix_en = pe;
    @(posedge clk);
    #1;
    if (!pe) begin
      check("hold_rgb", 32'({vif.r, vif.g, vif.b}), 32'(pre_rgb));
      check("hold_text_addr", 32'(vif.text_addr), 32'(pre_ta));
      check("hold_font_addr", 32'(vif.font_addr), 32'(pre_fa));
      check("hold_syncs", 32'({vif.hsync_out, vif.vsync_out, vif.blank_n_out}), 32'(pre_sy));
    end else begin
      blink = ((falls / 30) % 2) == 0;
      hist.push_back(s);
      n = hist.size();
      check("text_addr", 32'(vif.text_addr), 32'(cell_of(s)));
      if (n >= 2) begin
        samp_t p;
        logic [7:0] ch;
        p  = hist[n-2];
        ch = tram[cell_of(p)];
        check("font_addr", 32'(vif.font_addr), 32'((ch % 128) * 16 + p.y % 16));
      end
      if (n >= 3) begin
        samp_t q;
        q = hist[n-3];
        check("rgb", 32'({vif.r, vif.g, vif.b}), 32'(exp_rgb(q, blink)));
        check("syncs", 32'({vif.hsync_out, vif.vsync_out, vif.blank_n_out}),
              32'({q.hs, q.vs, q.br}));
      end
      if (prev_vs && !s.vs) falls++;
      prev_vs = s.vs;
    end
  endtask

  task automatic pix(input int xv, input int yv, input bit br, input bit hs, input bit vs);
    vif.x = 10'(xv);
    vif.y = 9'(yv);
    vif.bright = br;
    vif.hsync_in = hs;
    vif.vsync_in = vs;
    tick(1'b1);
    tick(1'b0);
  endtask

  task automatic flush();
    repeat (3) pix(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tram[i] = (i < 2400) ? 8'($urandom) : 8'h00;
    for (int i = 0; i < 2048; i++) from[i] = 8'($urandom);
    tram[0] = 8'h41;
    from[11'h410] = 8'h80;

    vif.pix_en = 1'b0; vif.x = '0; vif.y = '0; vif.bright = 1'b0;
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;
    vif.cursor_col = '0; vif.cursor_row = '0; vif.cursor_en = 1'b0;

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 32'({vif.r, vif.g, vif.b}), 32'h0);
    check("rst_hsync", 32'(vif.hsync_out), 32'h1);
    check("rst_vsync", 32'(vif.vsync_out), 32'h1);
    check("rst_blank_n", 32'(vif.blank_n_out), 32'h0);
    check("rst_text_addr", 32'(vif.text_addr), 32'h0);
    check("rst_font_addr", 32'(vif.font_addr), 32'h0);
    rst = 1'b0;
    hist.delete();
    falls = 0;
    prev_vs = 1'b1;

    // character 'A' at origin, first glyph column lit
    pix(0, 0, 1'b1, 1'b1, 1'b1);
    check("t2_text_addr", 32'(vif.text_addr), 32'd0);
    pix(1, 0, 1'b1, 1'b1, 1'b1);
    check("t2_font_addr", 32'(vif.font_addr), 32'h410);
    pix(2, 0, 1'b1, 1'b1, 1'b1);
    check("t2_rgb_x0", 32'({vif.r, vif.g, vif.b}), 32'hFFFFFF);
    pix(3, 0, 1'b1, 1'b1, 1'b1);
    check("t2_rgb_x1", 32'({vif.r, vif.g, vif.b}), 32'h000000);
    flush();

    // last visible pixel
    pix(639, 479, 1'b1, 1'b1, 1'b1);
    check("t3_text_addr", 32'(vif.text_addr), 32'd2399);
    pix(0, 0, 1'b0, 1'b1, 1'b1);
    check("t3_font_row", 32'(vif.font_addr[3:0]), 32'hF);
    flush();

    // inverse video
    tram[0] = 8'hC1;
    pix(0, 0, 1'b1, 1'b1, 1'b1);
    pix(1, 0, 1'b1, 1'b1, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b1);
    check("t4_rgb_x0", 32'({vif.r, vif.g, vif.b}), 32'h000000);
    pix(0, 0, 1'b0, 1'b1, 1'b1);
    check("t4_rgb_x1", 32'({vif.r, vif.g, vif.b}), 32'hFFFFFF);
    flush();

    // cursor blink on a blank cell at (5,2)
    tram[165] = 8'h20;
    from[11'h200] = 8'h00;
    vif.cursor_en = 1'b1; vif.cursor_col = 7'd5; vif.cursor_row = 5'd2;
    for (int ph = 0; ph < 3; ph++) begin
      pix(40, 32, 1'b1, 1'b1, 1'b1);
      pix(0, 0, 1'b0, 1'b1, 1'b1);
      pix(0, 0, 1'b0, 1'b1, 1'b1);
      check("t5_cursor", 32'({vif.r, vif.g, vif.b}), (ph % 2 == 0) ? 32'hFFFFFF : 32'h000000);
      if (ph < 2) begin
        repeat (30) begin
          pix(0, 500, 1'b0, 1'b1, 1'b0);
          pix(0, 500, 1'b0, 1'b1, 1'b1);
        end
      end
    end
    vif.cursor_en = 1'b0;
    flush();

    // pix_en stall mid-line, then hsync pulse latency
    pix(100, 10, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      vif.hsync_in = 1'($urandom);
      vif.x = 10'($urandom_range(0, 639));
      tick(1'b0);
    end
    pix(101, 10, 1'b1, 1'b0, 1'b1);
    pix(102, 10, 1'b1, 1'b1, 1'b1);
    pix(103, 10, 1'b1, 1'b1, 1'b1);
    check("t6_hsync_low", 32'(vif.hsync_out), 32'h0);
    pix(104, 10, 1'b1, 1'b1, 1'b1);
    check("t6_hsync_high", 32'(vif.hsync_out), 32'h1);

    // randomized stream with cursor-heavy pixels and frequent vsync falls
    vif.cursor_col = 7'($urandom_range(0, 79));
    vif.cursor_row = 5'($urandom_range(0, 29));
    vif.cursor_en  = 1'b1;
    for (int i = 0; i < 800; i++) begin
      int xv, yv;
      bit br;
      if ($urandom_range(0, 1) == 1) begin
        xv = int'(vif.cursor_col) * 8 + int'($urandom_range(0, 7));
        yv = int'(vif.cursor_row) * 16 + int'($urandom_range(0, 15));
      end else begin
        xv = int'($urandom_range(0, 799));
        yv = int'($urandom_range(0, 511));
      end
      br = (xv < 640) && (yv < 480) && ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) vif.cursor_en = ~vif.cursor_en;
      vif.x = 10'(xv);
      vif.y = 9'(yv);
      vif.bright = br;
      vif.hsync_in = ($urandom_range(0, 7) != 0);
      vif.vsync_in = ($urandom_range(0, 3) != 0);
      tick(1'b1);
      repeat ($urandom_range(1, 3)) tick(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
